// File: rtl/tex_pkg.sv
// Shared types and geometry constants for the tile-map renderer.
// The optional colour-key feature is controlled by the TEX_COLOR_KEY_EN macro.
package tex_pkg;

  // Geometry and data widths
  localparam int X_W        = 10;
  localparam int Y_W        = 10;
  localparam int TILE_LOG2  = 5;
  localparam int MAP_W_LOG2 = 4;
  localparam int MAP_H_LOG2 = 4;
  localparam int TYPE_W     = 5;
  localparam int COLOR_W    = 12;
  localparam int SB_W       = 2;

  // Derived sizes
  localparam int ADDR_W    = TYPE_W + 2 * TILE_LOG2;
  localparam int MAP_AW    = MAP_W_LOG2 + MAP_H_LOG2;
  localparam int MAP_DEPTH = 1 << MAP_AW;

  // Input-to-output latency in clock edges
  localparam int PIPE_LAT = 4;

  typedef logic [TYPE_W-1:0]  tex_type_t;
  typedef logic [COLOR_W-1:0] color_t;

  // Texel value treated as transparent when the colour key is enabled
  localparam color_t TEX_KEY_COLOR = 12'hF0F;

  // Per-pixel control bits that travel alongside the data path
  typedef struct packed {
    logic            valid;
    logic            in_map;
    logic [SB_W-1:0] sb;
  } side_t;

endpackage

// File: rtl/tex_tile_renderer_if.sv
// Pixel, tile-map write, texture ROM and output signals of the renderer.
// master = the surrounding system (video timing, game logic, ROM), slave = renderer.
interface tex_tile_renderer_if;
  import tex_pkg::*;

  // Incoming pixel stream
  logic                  pix_valid;
  logic [X_W-1:0]        pix_x;
  logic [Y_W-1:0]        pix_y;
  logic [SB_W-1:0]       pix_sb;

  // Tile map write port
  logic                  map_we;
  logic [MAP_W_LOG2-1:0] map_wx;
  logic [MAP_H_LOG2-1:0] map_wy;
  tex_type_t             map_wtype;

  // External synchronous texture ROM
  logic [ADDR_W-1:0]     tex_addr;
  color_t                tex_data;

  // Rendered output
  logic                  out_valid;
  color_t                out_color;
  logic [SB_W-1:0]       out_sb;

  // Replacement colour for keyed texels
  color_t                bg_color;

  modport master (
    output pix_valid, pix_x, pix_y, pix_sb,
    output map_we, map_wx, map_wy, map_wtype,
    output tex_data, bg_color,
    input  tex_addr, out_valid, out_color, out_sb
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_sb,
    input  map_we, map_wx, map_wy, map_wtype,
    input  tex_data, bg_color,
    output tex_addr, out_valid, out_color, out_sb
  );

endinterface

// File: rtl/tex_tile_map.sv
// Tile map storage: one write port and one synchronous read port, read-first.
// Held in flops so that reset clears every cell to tile type 0.
module tex_tile_map
  import tex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [MAP_AW-1:0] waddr,
  input  tex_type_t         wtype,
  input  logic [MAP_AW-1:0] raddr,
  output tex_type_t         rtype
);

  tex_type_t mem [MAP_DEPTH];

  // Cell storage with registered read; a same-edge write is seen by the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: memories are normally left unreset, but the map must come up all type 0,
      // so every entry is cleared here; this is why the map is not a RAM macro.
      for (int i = 0; i < MAP_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rtype <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wtype;
      end
      // NOTE: non-blocking assignments make this read sample the pre-write
      // contents, which is exactly the read-first behaviour on a collision.
      rtype <= mem[raddr];
    end
  end

endmodule

// File: rtl/tex_tile_renderer.sv
// Fixed-latency tile-map renderer: pixel -> map cell -> tile type -> texel -> colour.
// Four register stages; never stalls. Optional feature macro: TEX_COLOR_KEY_EN
// (texels equal to TEX_KEY_COLOR are replaced by bg_color).
module tex_tile_renderer
  import tex_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  tex_tile_renderer_if.slave bus
);

  // ---------------------------------------------------------------------------
  // S1: split the pixel position into cell and in-tile coordinates
  // ---------------------------------------------------------------------------
  logic [X_W-1:0] cell_x_full;
  logic [Y_W-1:0] cell_y_full;
  logic           in_map_c;

  assign cell_x_full = bus.pix_x >> TILE_LOG2;
  assign cell_y_full = bus.pix_y >> TILE_LOG2;

  // Compared at full width so far-off-map pixels cannot alias into the map
  assign in_map_c = (cell_x_full < X_W'(2 ** MAP_W_LOG2)) &&
                    (cell_y_full < Y_W'(2 ** MAP_H_LOG2));

  logic [TILE_LOG2-1:0]  s1_tx;
  logic [TILE_LOG2-1:0]  s1_ty;
  logic [MAP_W_LOG2-1:0] s1_cell_x;
  logic [MAP_H_LOG2-1:0] s1_cell_y;

  // Register in-tile texel coordinates and the map cell to look up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_tx     <= '0;
      s1_ty     <= '0;
      s1_cell_x <= '0;
      s1_cell_y <= '0;
    end else begin
      s1_tx     <= bus.pix_x[TILE_LOG2-1:0];
      s1_ty     <= bus.pix_y[TILE_LOG2-1:0];
      s1_cell_x <= cell_x_full[MAP_W_LOG2-1:0];
      s1_cell_y <= cell_y_full[MAP_H_LOG2-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control bits (valid, in_map, sideband) travel S1..S3, then feed S4
  // ---------------------------------------------------------------------------
  side_t side_q [PIPE_LAT-1];

  // Shift control bits along with the pixel; sideband moves even when invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT - 1; i++) begin
        side_q[i] <= '0;
      end
    end else begin
      side_q[0] <= '{valid: bus.pix_valid, in_map: in_map_c, sb: bus.pix_sb};
      for (int i = 1; i < PIPE_LAT - 1; i++) begin
        side_q[i] <= side_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: tile type lookup; the ROM address is formed purely from flop outputs
  // ---------------------------------------------------------------------------
  tex_type_t            s2_type;
  logic [TILE_LOG2-1:0] s2_tx;
  logic [TILE_LOG2-1:0] s2_ty;

  tex_tile_map u_map (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.map_we),
    .waddr ({bus.map_wy, bus.map_wx}),
    .wtype (bus.map_wtype),
    .raddr ({s1_cell_y, s1_cell_x}),
    .rtype (s2_type)
  );

  // Align texel coordinates with the registered tile type
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_tx <= '0;
      s2_ty <= '0;
    end else begin
      s2_tx <= s1_tx;
      s2_ty <= s1_ty;
    end
  end

  assign bus.tex_addr = {s2_type, s2_ty, s2_tx};

  // ---------------------------------------------------------------------------
  // S3 is the ROM's own output register; S4 selects and registers the colour
  // ---------------------------------------------------------------------------
  color_t texel;

`ifdef TEX_COLOR_KEY_EN
  assign texel = (bus.tex_data == TEX_KEY_COLOR) ? bus.bg_color : bus.tex_data;
`else
  logic unused_bg;
  assign texel     = bus.tex_data;
  assign unused_bg = ^bus.bg_color;
`endif

  side_t           s3_side;
  logic            out_valid_q;
  color_t          out_color_q;
  logic [SB_W-1:0] out_sb_q;

  assign s3_side = side_q[PIPE_LAT-2];

  // Output stage: blank invalid and off-map pixels to black
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_color_q <= '0;
      out_sb_q    <= '0;
    end else begin
      out_valid_q <= s3_side.valid;
      out_sb_q    <= s3_side.sb;
      out_color_q <= (s3_side.valid && s3_side.in_map) ? texel : '0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_color = out_color_q;
  assign bus.out_sb    = out_sb_q;

endmodule

// File: doc/tex_tile_renderer.md
Name: tex_tile_renderer

Overview:
- Pipelined tile-map renderer for the VGA path, with a fixed latency.
- Per pixel, it converts the pixel position to a map cell and looks the tile type up in an internal writable tile map.
- It then fetches the texel from an external synchronous texture ROM and outputs the colour, blanked outside the map area.
- Game logic updates the tile map through a write port. Sync/sideband bits are delayed to match the pixel latency.

Parameters:
- X_W, 10, pixel x coordinate width
- Y_W, 10, pixel y coordinate width
- TILE_LOG2, 5, log2 of tile edge in pixels (32x32 tiles)
- MAP_W_LOG2, 4, log2 of map width in tiles (16)
- MAP_H_LOG2, 4, log2 of map height in tiles (16)
- TYPE_W, 5, tile type width (32 textures)
- COLOR_W, 12, RGB444 pixel width
- SB_W, 2, sideband width (hsync, vsync)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- pix_valid  in  1  display-enable; pixel coordinate is valid
- pix_x  in  X_W  pixel column
- pix_y  in  Y_W  pixel row
- pix_sb  in  SB_W  sideband, delayed with the pixel
- map_we  in  1  tile map write enable
- map_wx  in  MAP_W_LOG2  write cell column
- map_wy  in  MAP_H_LOG2  write cell row
- map_wtype  in  TYPE_W  tile type to store
- tex_addr  out  TYPE_W+2*TILE_LOG2  ROM address {type, ty, tx}, registered
- tex_data  in  COLOR_W  ROM data, one cycle after tex_addr
- out_valid  out  1  output pixel valid
- out_color  out  COLOR_W  pixel colour
- out_sb  out  SB_W  delayed sideband
- bg_color  in  COLOR_W  replacement colour (used only with the optional feature)

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_color=0, out_sb=0, tex_addr=0.
  - All pipeline valids cleared.
  - All tile map entries cleared to type 0.
- Reset mid-frame discards in-flight pixels. There is no output until 4 cycles after the first pix_valid following release.
- Latency: inputs sampled at edge k appear on the out_* ports after edge k+4.
  - The pipeline is fixed-latency and never stalls.
  - pix_sb passes through the same 4 stages regardless of pix_valid.
- S1 (edge k+1):
  - Register tx = pix_x[TILE_LOG2-1:0], ty = pix_y[TILE_LOG2-1:0].
  - cell_x = pix_x >> TILE_LOG2; cell_y = pix_y >> TILE_LOG2.
  - in_map = (pix_x >> TILE_LOG2) < 2^MAP_W_LOG2 and (pix_y >> TILE_LOG2) < 2^MAP_H_LOG2, compared at full width with no truncation before the compare.
- S2 (edge k+2):
  - Synchronous tile map read at {cell_y, cell_x}.
  - Drive tex_addr = {type, ty, tx} registered.
- S3 (edge k+3): ROM returns tex_data; carry in_map, valid, sb alongside.
- S4 (edge k+4):
  - out_color = (valid & in_map) ? tex_data : 0.
  - out_valid = valid; out_sb = sb.
  - When valid=0, out_color=0.
- Tile map write:
  - map_we writes map_wtype at {map_wy, map_wx} on the edge.
  - Read-first: a read of the same cell in the same cycle returns the old type; the new type is visible to reads from the next edge.
- Out-of-map pixels: tex_addr still updates, but the result is forced black. Default geometry blanks x>=512 and y>=512.
- Width: shifts are logical. tx/ty are the low TILE_LOG2 bits, so wrap-around inside a tile is inherent.

Optional Feature:
- Macro: TEX_COLOR_KEY_EN
- When defined: a texel equal to package constant TEX_KEY_COLOR (12'hF0F) is replaced in S4 by bg_color; this applies only when valid & in_map.
- When not defined: bg_color is unused and tex_data is passed through unchanged.
- Latency is unaffected either way.

Decomposition:
- Package tex_pkg holds:
  - TEX_KEY_COLOR
  - the tex_type_t and color_t typedefs
  - localparams for address width (TYPE_W+2*TILE_LOG2) and map depth (2^(MAP_W_LOG2+MAP_H_LOG2))
  - PIPE_LAT = 4
- One sub-module: tex_tile_map, the dual-port (1 write, 1 sync read, read-first) tile storage with async reset clear.

Test Plan:
- Reset then map clear:
  - Stimulus: assert rst mid-stream, release, drive pix (0,0) valid; ROM model returns addr-derived data.
  - Required: out_valid=0 for 4 cycles, then out_color = ROM[{5'd0,5'd0,5'd0}].
- Write then render:
  - Stimulus: write type 7 at cell (3,2), then pixel x=100, y=70.
  - Required: tex_addr = {5'd7, 5'd6, 5'd4}; out_color = ROM of that address exactly 4 edges after the pixel.
- Read/write collision:
  - Stimulus: cell (3,2) holds type 7; write type 9 there on the same edge as the S1→S2 read.
  - Required: the pixel uses type 7, and the next pixel in that cell uses 9.
- Out-of-map blanking:
  - Stimulus: x=600, y=10 and x=10, y=520, both with pix_valid=1.
  - Required: out_valid=1 and out_color=0.
- Sideband alignment:
  - Stimulus: toggle pix_sb with pix_valid=0 during blanking.
  - Required: out_sb mirrors it 4 cycles later, out_valid=0, out_color=0.
- Colour key (TEX_COLOR_KEY_EN defined):
  - Stimulus: ROM returns 12'hF0F, bg_color = 12'h123.
  - Required: out_color = 12'h123; without the macro, out_color = 12'hF0F.
